id_hazard_ctrl: RTL and testbench

//  Owns the IF/ID pipeline register and sequences the decode stage of the RV32I core.

---
 rtl/core_pkg.sv | 20 ++
 rtl/id_src_use.sv | 15 +
 rtl/id_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_id_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: base opcodes and the decode-stage sequencing states.
package core_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        ID_RUN   = 2'd0,
        ID_STALL = 2'd1,
        ID_FLUSH = 2'd2
    } id_state_e;

endpackage

// File: rtl/id_src_use.sv
// Opcode -> source-register usage; also consumed by the forwarding unit.
module id_src_use
    import core_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic       uses_rs1_o,
    output logic       uses_rs2_o
);

    always_comb begin
        uses_rs1_o = !((opcode_i == OPC_LUI) || (opcode_i == OPC_AUIPC) || (opcode_i == OPC_JAL));
        uses_rs2_o = (opcode_i == OPC_OP) || (opcode_i == OPC_STORE) || (opcode_i == OPC_BRANCH);
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// IF/ID pipeline register plus decode-stage sequencing: load-use stall,
// post-redirect squash and downstream freeze.
module id_hazard_ctrl
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned PCNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_valid,
    input  logic [31:0]       if_instr,
    input  logic [XLEN-1:0]   if_pc,
    output logic              if_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [XLEN-1:0]   id_pc,
    output logic [6:0]        id_opcode,
    output logic              id_flush,
    output logic              idex_bubble,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_rd,
    input  logic              ex_branch_taken,
    input  logic              ex_stall,
    output logic [PCNT_W-1:0] stall_cnt
);

    localparam logic [2:0] FCNT_INIT = 3'(FLUSH_CYCLES - 1);

    id_state_e         state_q;
    logic [2:0]        fcnt_q;
    logic              id_valid_q;
    logic [31:0]       id_instr_q;
    logic [XLEN-1:0]   id_pc_q;
    logic [PCNT_W-1:0] stall_cnt_q;

    logic uses_rs1;
    logic uses_rs2;
    logic src_match;
    logic hazard;
    logic redirect;

    id_src_use u_src_use (
        .opcode_i   (id_instr_q[6:0]),
        .uses_rs1_o (uses_rs1),
        .uses_rs2_o (uses_rs2)
    );

    // Hazard is gated by RUN: after a stall the bubble occupies EX, so it cannot re-fire.
    always_comb begin
        redirect    = ex_branch_taken & ~ex_stall;
        src_match   = (uses_rs1 && (ex_rd == id_instr_q[19:15]))
                   || (uses_rs2 && (ex_rd == id_instr_q[24:20]));
        hazard      = (state_q == ID_RUN) && id_valid_q && ex_mem_read
                   && (ex_rd != 5'd0) && src_match;
        id_flush    = redirect | (state_q == ID_FLUSH) | ~id_valid_q;
        idex_bubble = id_flush | hazard;
        if_ready    = ~ex_stall & ~hazard;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ID_RUN;
            fcnt_q      <= '0;
            id_valid_q  <= 1'b0;
            id_instr_q  <= '0;
            id_pc_q     <= '0;
            stall_cnt_q <= '0;
        end else if (redirect) begin
            id_valid_q <= 1'b0;
            state_q    <= ID_FLUSH;
            fcnt_q     <= FCNT_INIT;
        end else if (ex_stall) begin
            state_q <= state_q;
        end else if (hazard) begin
            state_q <= ID_STALL;
            if (stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + PCNT_W'(1);
            end
        end else if (state_q == ID_FLUSH) begin
            id_valid_q <= 1'b0;
            if (fcnt_q == 3'd0) begin
                state_q <= ID_RUN;
            end else begin
                fcnt_q <= fcnt_q - 3'd1;
            end
        end else begin
            id_valid_q <= if_valid;
            if (if_valid) begin
                id_instr_q <= if_instr;
                id_pc_q    <= if_pc;
            end
            state_q <= ID_RUN;
        end
    end

    assign id_valid  = id_valid_q;
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:0];
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: two flush beats, 4-bit stall counter.
module tb_id_hazard_ctrl;

    localparam int unsigned XLEN = 32;
    localparam int unsigned PCNT_W = 4;

    localparam logic [31:0] ADD  = 32'h00728333; // add  x6,x5,x7
    localparam logic [31:0] LUI1 = 32'h000122B7; // lui  x5,0x12
    localparam logic [31:0] LUI2 = 32'h000282B7; // lui  x5,0x28 (rs1 field = 5)
    localparam logic [31:0] ADDI = 32'h00100093; // addi x1,x0,1
    localparam logic [31:0] SW   = 32'h00512023; // sw   x5,0(x2)
    localparam logic [31:0] NOP  = 32'h00000013;

    logic clk = 1'b0;
    logic rst_n;
    logic if_valid;
    logic [31:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic if_ready, id_valid, id_flush, idex_bubble;
    logic [31:0] id_instr;
    logic [XLEN-1:0] id_pc;
    logic [6:0] id_opcode;
    logic ex_mem_read, ex_branch_taken, ex_stall;
    logic [4:0] ex_rd;
    logic [PCNT_W-1:0] stall_cnt;

    int total = 0;
    int bad = 0;
    logic [PCNT_W-1:0] exp_cnt;

    always #5 clk = ~clk;

    id_hazard_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .PCNT_W(PCNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_opcode(id_opcode),
        .id_flush(id_flush), .idex_bubble(idex_bubble),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_stall(ex_stall), .stall_cnt(stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] pc,
                         input logic mr, input logic [4:0] rd, input logic bt, input logic st);
        if_valid = v; if_instr = ins; if_pc = pc;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = bt; ex_stall = st;
        #1;
    endtask

    task automatic load_id(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        drive(1'b1, ins, pc, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_power_on();
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        #10;
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL por_valid got=%b exp=0", id_valid); end
        total++; if (id_flush !== 1'b1 || idex_bubble !== 1'b1 || if_ready !== 1'b1) begin bad++;
            $display("FAIL por_ctrl got flush=%b bub=%b rdy=%b exp 1/1/1", id_flush, idex_bubble, if_ready); end
        total++; if (id_instr !== 32'h0 || id_pc !== '0 || stall_cnt !== '0) begin bad++;
            $display("FAIL por_regs got instr=%h pc=%h cnt=%0d exp 0/0/0", id_instr, id_pc, stall_cnt); end
        rst_n = 1'b1;
        exp_cnt = '0;
    endtask

    task automatic test_load_use();
        load_id(ADD, 32'h100);
        drive(1'b1, NOP, 32'h104, 1'b1, 5'd5, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b0 || idex_bubble !== 1'b1 || id_flush !== 1'b0) begin bad++;
            $display("FAIL lu_stall got rdy=%b bub=%b flush=%b exp 0/1/0", if_ready, idex_bubble, id_flush); end
        total++; if (id_opcode !== 7'h33) begin bad++; $display("FAIL lu_opcode got=%h exp=33", id_opcode); end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        total++; if (id_instr !== ADD || id_valid !== 1'b1) begin bad++;
            $display("FAIL lu_hold got instr=%h v=%b exp=%h/1", id_instr, id_valid, ADD); end
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        total++; if (if_ready !== 1'b1 || idex_bubble !== 1'b0) begin bad++;
            $display("FAIL lu_release got rdy=%b bub=%b exp 1/0", if_ready, idex_bubble); end
        tick();
        total++; if (id_instr !== NOP || id_pc !== 32'h104 || id_valid !== 1'b1) begin bad++;
            $display("FAIL lu_next got instr=%h pc=%h v=%b exp=%h/104/1", id_instr, id_pc, id_valid, NOP); end
    endtask

    task automatic test_no_false_hazard();
        load_id(LUI1, 32'h200);
        drive(1'b1, NOP, 32'h204, 1'b1, 5'd5, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL nf_lui1 got rdy=%b exp=1", if_ready); end
        load_id(LUI2, 32'h208);
        drive(1'b1, NOP, 32'h20c, 1'b1, 5'd5, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b1 || idex_bubble !== 1'b0) begin bad++;
            $display("FAIL nf_lui2 got rdy=%b bub=%b exp 1/0", if_ready, idex_bubble); end
        load_id(ADDI, 32'h210);
        drive(1'b1, NOP, 32'h214, 1'b1, 5'd0, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL nf_x0 got rdy=%b exp=1", if_ready); end
        drive(1'b1, NOP, 32'h214, 1'b1, 5'd1, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL nf_addi_rs2 got rdy=%b exp=1", if_ready); end
        load_id(SW, 32'h218);
        drive(1'b1, NOP, 32'h21c, 1'b1, 5'd5, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b0 || idex_bubble !== 1'b1) begin bad++;
            $display("FAIL nf_sw got rdy=%b bub=%b exp 0/1", if_ready, idex_bubble); end
        tick();
        exp_cnt = exp_cnt + 1'b1;
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL nf_sw_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        drive(1'b1, NOP, 32'h21c, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_redirect();
        load_id(ADD, 32'h300);
        drive(1'b1, 32'h00000113, 32'h304, 1'b0, 5'd0, 1'b1, 1'b0);
        total++; if (id_flush !== 1'b1 || idex_bubble !== 1'b1 || if_ready !== 1'b1) begin bad++;
            $display("FAIL rd_cycle got flush=%b bub=%b rdy=%b exp 1/1/1", id_flush, idex_bubble, if_ready); end
        tick();
        drive(1'b1, 32'h00000193, 32'h400, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (id_valid !== 1'b0 || id_flush !== 1'b1) begin bad++;
            $display("FAIL rd_f1 got v=%b flush=%b exp 0/1", id_valid, id_flush); end
        tick();
        drive(1'b1, 32'h00000213, 32'h404, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (id_valid !== 1'b0 || id_flush !== 1'b1) begin bad++;
            $display("FAIL rd_f2 got v=%b flush=%b exp 0/1", id_valid, id_flush); end
        tick();
        drive(1'b1, 32'h00000293, 32'h408, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        total++; if (id_valid !== 1'b1 || id_instr !== 32'h00000293 || id_pc !== 32'h408 || id_flush !== 1'b0) begin bad++;
            $display("FAIL rd_capture got v=%b instr=%h pc=%h flush=%b exp 1/00000293/408/0",
                     id_valid, id_instr, id_pc, id_flush); end
    endtask

    task automatic test_simultaneous();
        load_id(ADD, 32'h500);
        drive(1'b1, NOP, 32'h504, 1'b1, 5'd5, 1'b1, 1'b0);
        total++; if (idex_bubble !== 1'b1 || id_flush !== 1'b1) begin bad++;
            $display("FAIL sim_bubble got bub=%b flush=%b exp 1/1", idex_bubble, id_flush); end
        tick();
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL sim_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
        total++; if (id_valid !== 1'b0 || id_flush !== 1'b1) begin bad++;
            $display("FAIL sim_flush got v=%b flush=%b exp 0/1", id_valid, id_flush); end
        drive(1'b1, NOP, 32'h600, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        tick();
    endtask

    task automatic test_ex_stall();
        load_id(LUI1, 32'h700);
        drive(1'b1, NOP, 32'h704, 1'b1, 5'd5, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++; if (if_ready !== 1'b0 || id_flush !== 1'b0 || id_valid !== 1'b1 || id_instr !== LUI1) begin bad++;
                $display("FAIL st_freeze%0d got rdy=%b flush=%b v=%b instr=%h exp 0/0/1/%h",
                         i, if_ready, id_flush, id_valid, id_instr, LUI1); end
            tick();
        end
        total++; if (stall_cnt !== exp_cnt || id_pc !== 32'h700) begin bad++;
            $display("FAIL st_held got cnt=%0d pc=%h exp=%0d/700", stall_cnt, id_pc, exp_cnt); end
        drive(1'b1, NOP, 32'h704, 1'b0, 5'd0, 1'b1, 1'b0);
        total++; if (id_flush !== 1'b1 || if_ready !== 1'b1) begin bad++;
            $display("FAIL st_release got flush=%b rdy=%b exp 1/1", id_flush, if_ready); end
        tick();
        drive(1'b0, NOP, 32'h800, 1'b0, 5'd0, 1'b0, 1'b0);
        total++; if (id_valid !== 1'b0) begin bad++; $display("FAIL st_redirect got v=%b exp=0", id_valid); end
        tick();
        tick();
    endtask

    task automatic test_reset();
        load_id(ADD, 32'h900);
        drive(1'b1, NOP, 32'h904, 1'b1, 5'd5, 1'b0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        total++; if (id_valid !== 1'b0 || id_flush !== 1'b1 || if_ready !== 1'b1 || stall_cnt !== '0) begin bad++;
            $display("FAIL rst_mid got v=%b flush=%b rdy=%b cnt=%0d exp 0/1/1/0",
                     id_valid, id_flush, if_ready, stall_cnt); end
        #1 rst_n = 1'b1;
        exp_cnt = '0;
        drive(1'b1, NOP, 32'ha00, 1'b1, 5'd5, 1'b0, 1'b0);
        total++; if (if_ready !== 1'b1) begin bad++; $display("FAIL rst_nostall got rdy=%b exp=1", if_ready); end
        tick();
        total++; if (id_valid !== 1'b1 || id_pc !== 32'ha00 || stall_cnt !== '0) begin bad++;
            $display("FAIL rst_resume got v=%b pc=%h cnt=%0d exp 1/a00/0", id_valid, id_pc, stall_cnt); end
    endtask

    task automatic test_saturation();
        load_id(ADD, 32'hb00);
        drive(1'b1, ADD, 32'hb00, 1'b1, 5'd5, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) begin
            tick();
            tick();
        end
        exp_cnt = '1;
        total++; if (stall_cnt !== exp_cnt || if_ready !== 1'b0) begin bad++;
            $display("FAIL sat_full got cnt=%0d rdy=%b exp=%0d/0", stall_cnt, if_ready, exp_cnt); end
        tick();
        total++; if (stall_cnt !== exp_cnt) begin bad++; $display("FAIL sat_hold got=%0d exp=%0d", stall_cnt, exp_cnt); end
        drive(1'b0, NOP, '0, 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        test_power_on();
        test_load_use();
        test_no_false_hazard();
        test_redirect();
        test_simultaneous();
        test_ex_stall();
        test_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
